// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the seven-segment display blocks.
package sev_seg_pkg;

    // Playback controller states.
    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Active-low blanking values for the segment and anode pins.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F; index 0 is the
    // rightmost element. b and d use the lowercase glyphs.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Segment pattern lookup for one hex nibble.
    function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
    import sev_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure table lookup; no state.
    always_comb begin
        seg = hex_seg(hex);
    end

endmodule

// File: rtl/sev_seg_playback.sv
// Plays back a snapshot of the four-entry history word on a 4-digit
// multiplexed seven-segment display, one entry at a time.
module sev_seg_playback
    import sev_seg_pkg::*;
#(
    parameter int REFRESH_BITS = 17,
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [63:0] data_in,
    input  logic        start,
    input  logic        next,
    input  logic        auto_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        busy,
    output logic [1:0]  entry_idx,
    output logic        done
);

    localparam int DWELL_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    // Controller state.
    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [63:0]         snap_q, snap_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start_q, start_d;
    logic                next_q, next_d;

    // Scan and display state.
    logic [REFRESH_BITS-1:0] scan_q, scan_d;
    logic [6:0]              seg_q, seg_d;
    logic [3:0]              an_q, an_d;
    logic                    dp_q, dp_d;

    // Decode helpers.
    logic       start_e;
    logic       next_e;
    logic       dwell_exp;
    logic [1:0] digit;
    logic [3:0] nibble;
    logic [6:0] hex_pattern;

    // One action per press: rising edges of the already-debounced buttons.
    assign start_e   = start & ~start_q;
    assign next_e    = next & ~next_q;
    assign dwell_exp = auto_en && (dwell_q == DWELL_LAST);

    // Digit select from the top two scan bits; nibble of the entry on show.
    assign digit  = scan_q[REFRESH_BITS-1 -: 2];
    assign nibble = snap_q[{idx_q, digit, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .hex (nibble),
        .seg (hex_pattern)
    );

    // Next-state logic for the playback controller; start has priority over
    // any advance, and next plus dwell expiry together advance only once.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        start_d = start;
        next_d  = next;

        unique case (state_q)
            IDLE: begin
                if (start_e) begin
                    state_d = SHOW;
                    snap_d  = data_in;
                    idx_d   = 2'd0;
                    dwell_d = '0;
                end
            end
            SHOW: begin
                if (start_e) begin
                    snap_d  = data_in;
                    idx_d   = 2'd0;
                    dwell_d = '0;
                end else if (next_e || dwell_exp) begin
                    dwell_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (auto_en) begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                dwell_d = '0;
            end
        endcase

        busy_d = (state_d == SHOW);
    end

    // Playback controller registers, including its registered status outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            dwell_q <= '0;
            snap_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            // NOTE: edge history resets to 1 so a button held through reset
            // must be released and pressed again before it counts.
            start_q <= 1'b1;
            next_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            snap_q  <= snap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
            next_q  <= next_d;
        end
    end

    // Display drive: blank in IDLE, otherwise the selected digit with the
    // decimal point marking which entry is on show.
    always_comb begin
        scan_d = scan_q + 1'b1;
        seg_d  = SEG_BLANK;
        an_d   = AN_OFF;
        dp_d   = 1'b1;
        if (state_q == SHOW) begin
            seg_d = hex_pattern;
            an_d  = ~(4'b0001 << digit);
            dp_d  = (digit != idx_q);
        end
    end

    // Free-running scan counter and registered display pins.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            scan_q <= '0;
            seg_q  <= SEG_BLANK;
            an_q   <= AN_OFF;
            dp_q   <= 1'b1;
        end else begin
            scan_q <= scan_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            dp_q   <= dp_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign dp        = dp_q;
    assign busy      = busy_q;
    assign entry_idx = idx_q;
    assign done      = done_q;

endmodule

// File: doc/sev_seg_playback.md
Name: sev_seg_playback

Overview:
- Reader side of the seven-segment history register.
- Takes the 64-bit history (four 16-bit entries, entry 0 newest in bits 15:0), snapshots it on a start press, and plays the entries back one at a time on the 4-digit multiplexed display.
- Steps through entries manually (next press) or automatically (dwell timer); returns to idle after the oldest entry.
- Sits between the history register output and the board seg/an/dp pins.

Parameters:
- REFRESH_BITS, 17: width of the free-running scan counter; each digit is active for 2^(REFRESH_BITS-2) cycles.
- DWELL_CYCLES, 100_000_000: cycles each entry is shown in auto mode (1 s at 100 MHz); must be ≥2.

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-high reset
- data_in  in  64  history word; entry k = data_in[16k+15:16k]
- start  in  1  level (button); rising edge starts or restarts playback
- next  in  1  level (button); rising edge advances one entry
- auto_en  in  1  1 = advance on the dwell timer as well as on next
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- an  out  4  digit enables, active-low; an[0] = rightmost digit
- dp  out  1  decimal point, active-low
- busy  out  1  high while in SHOW
- entry_idx  out  2  entry currently shown
- done  out  1  one-cycle pulse when playback ends

Behaviour:
- Reset (async, clr=1):
  - Outputs: seg=7'h7F, an=4'hF, dp=1, busy=0, done=0, entry_idx=0.
  - Internal: snapshot=0, dwell=0, scan counter=0, FSM=IDLE.
  - Edge-detect history registers reset to 1, so a button held through reset produces no edge until it is released.
- Edge detect: start_e = start & ~start_q and next_e = next & ~next_q, with start_q/next_q as 1-cycle registers. This gives one action per press. Inputs are already synchronous and debounced upstream.
- FSM states:
  - IDLE: display blanked (an=4'hF, seg=7'h7F, dp=1).
    - start_e → SHOW: snapshot<=data_in, idx<=0, dwell<=0.
  - SHOW: display nibbles of snapshot entry idx.
    - Advance when next_e, or when auto_en && dwell==DWELL_CYCLES-1.
    - Advance at idx<3: idx<=idx+1, dwell<=0.
    - Advance at idx==3: → IDLE, done=1 for exactly one cycle, idx<=0.
    - start_e in SHOW: re-snapshot data_in, idx<=0, dwell<=0, stay in SHOW, no done pulse.
- Dwell counter:
  - Counts only in SHOW with auto_en=1.
  - Holds its value while auto_en=0.
  - Clears on every advance and on every restart.
- Simultaneous events:
  - start_e with next_e or a dwell expiry: start wins.
  - next_e with a dwell expiry in the same cycle: a single advance.
- Data changes on data_in after the snapshot do not affect playback.
- Scan:
  - The scan counter is free-running in all states.
  - Digit select d = scan[REFRESH_BITS-1 -: 2].
  - Digit d shows nibble snapshot[16*idx+4d+3 -: 4], hex-decoded (0-9, A-F; b and d lowercase).
  - an = ~(1<<d).
  - dp=0 only on digit d==idx, indicating the entry number.
- Latency:
  - seg/an/dp are registered and lag the select/idx change by 1 cycle.
  - busy, entry_idx and done are registered and change on the same edge as the FSM.

Decomposition:
- Package sev_seg_pkg:
  - state enum {IDLE, SHOW}
  - SEG_BLANK=7'h7F, AN_OFF=4'hF
  - the 16-entry hex segment constant table
- Sub-module hex_to_seg (4-bit in, 7-bit active-low out, combinational). It is used once here and shared with other display blocks.

Test Plan: (bench uses REFRESH_BITS=4, DWELL_CYCLES=8)
1. Reset with start held high; release clr:
   - seg=7F, an=F, busy=0 after reset.
   - No playback until start falls and rises again.
2. data_in=64'h4444_3333_2222_ABCD, start pulse, auto_en=0:
   - busy=1, entry_idx=0.
   - Scan shows digits D,C,B,A on an[0..3] (seg 7'h21 for d on an=4'b1110).
   - dp=0 only when an=4'b1110.
3. From SHOW, 4 next presses, each held 3 cycles:
   - entry_idx goes 1, 2, 3, with digits 2222/3333/4444.
   - The 4th press → IDLE, done high exactly 1 cycle, display blank.
   - Each press advances exactly once.
4. auto_en=1, no next:
   - entry_idx increments every 8 cycles.
   - done asserts 32 cycles after the start edge.
   - With auto_en=0 at cycle 5 of an entry, idx holds; re-enabling resumes at dwell=5.
5. Change data_in to all-F mid-playback:
   - Display keeps the snapshot.
   - A start press then resets to idx=0 showing FFFF, with no done pulse.
6. start and next rising together in SHOW at idx=2 → idx=0 with a new snapshot. Assert clr mid-SHOW → outputs blank immediately (async), busy=0.
